// File: rtl/zeus_rpc_pkg.sv
// Shared constants, byte-order helpers and FSM state type for the TX encapsulation path.
// ZEUS_TX_VLAN_EN selects the 802.1Q-tagged header size.
package zeus_rpc_pkg;

  localparam logic [15:0] ETHTYPE_IP      = 16'h0800;
  localparam logic [15:0] ETHTYPE_VLAN    = 16'h8100;
  localparam logic [3:0]  IP_VERSION_IPV4 = 4'd4;
  localparam logic [3:0]  IP_IHL_WORDS    = 4'd5;
  localparam logic [7:0]  IPPROTO_UDP     = 8'd17;

  localparam int ETH_HEADER_BYTES  = 14;
  localparam int VLAN_HEADER_BYTES = 4;
  localparam int IP_HEADER_BYTES   = 20;
  localparam int UDP_HEADER_BYTES  = 8;
`ifdef ZEUS_TX_VLAN_EN
  localparam int TX_HEADER_BYTES = ETH_HEADER_BYTES + VLAN_HEADER_BYTES + IP_HEADER_BYTES + UDP_HEADER_BYTES;
`else
  localparam int TX_HEADER_BYTES = ETH_HEADER_BYTES + IP_HEADER_BYTES + UDP_HEADER_BYTES;
`endif

  typedef enum logic [1:0] {HEAD, BODY, TAIL, DROP} tx_encap_state_t;

  // Network fields are big-endian while stream byte 0 sits in the LSBs.
  function automatic logic [15:0] swap_bytes_2(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] swap_bytes_4(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [47:0] swap_bytes_6(input logic [47:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
  endfunction

  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/ip_hdr_checksum.sv
// Combinational IPv4 header checksum over a 160-bit header (checksum field zeroed).
module ip_hdr_checksum
  import zeus_rpc_pkg::*;
(
  input  logic [159:0] hdr_i,
  output logic [15:0]  csum_o
);

  logic [19:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      sum = sum + {4'b0, hdr_i[16*i +: 16]};
    end
  end

  // Ten words carry at most 4 bits; one end-around add absorbs them completely.
  assign csum_o = ~ones_add16(sum[15:0], {12'b0, sum[19:16]});

endmodule

// File: rtl/tx_udp_encap.sv
// Prepends Ethernet/IPv4/UDP headers to payload packets and drops lookup misses.
// Define ZEUS_TX_VLAN_EN to insert an 802.1Q tag (adds my_config_vlanTci).
module tx_udp_encap
  import zeus_rpc_pkg::*;
#(
  parameter int         DATA_WIDTH   = 512,
  parameter logic [5:0] IP_UDP_DSCP  = 6'd0,
  parameter logic [1:0] IP_UDP_ECN   = 2'd0,
  parameter logic [2:0] IP_UDP_FLAGS = 3'd2,
  parameter logic [7:0] IP_UDP_TTL   = 8'd64,
  parameter int         DROP_CNT_W   = 32
) (
  input  logic                    tx_axis_aclk,
  input  logic                    tx_axis_areset,
  input  logic [31:0]             my_config_ipAddr,
  input  logic [47:0]             my_config_macAddr,
  input  logic [15:0]             my_config_udpPort,
`ifdef ZEUS_TX_VLAN_EN
  input  logic [15:0]             my_config_vlanTci,
`endif
  input  logic [DATA_WIDTH-1:0]   packet_fifo_tdata,
  input  logic [DATA_WIDTH/8-1:0] packet_fifo_tkeep,
  input  logic                    packet_fifo_tlast,
  input  logic                    packet_fifo_tvalid,
  output logic                    packet_fifo_tready,
  input  logic [96:0]             connection_fifo_tdata,
  input  logic                    connection_fifo_tvalid,
  output logic                    connection_fifo_tready,
  input  logic [15:0]             payload_length_fifo_tdata,
  input  logic                    payload_length_fifo_tvalid,
  output logic                    payload_length_fifo_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DROP_CNT_W-1:0]   stat_drop_count,
  output logic [1:0]              dbg_state_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int H     = TX_HEADER_BYTES;
  localparam int HB    = 8 * H;
  localparam int PB    = BYTES - H;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the output beat stays frozen while m_axis_tvalid is high and m_axis_tready is low.
  tx_encap_state_t        state_q, state_d, after_beat;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [BYTES-1:0]       tkeep_q, tkeep_d;
  logic [HB-1:0]          carry_q, carry_d;
  logic [H-1:0]           tail_keep_q, tail_keep_d;
  logic [15:0]            ip_id_q, ip_id_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic        conn_hit;
  logic [47:0] dst_mac;
  logic [15:0] dst_port;
  logic [31:0] dst_ip;
  assign {conn_hit, dst_mac, dst_port, dst_ip} = connection_fifo_tdata;

  logic [15:0]  ip_total_len, udp_len, ip_flags_frag, ip_csum;
  logic [7:0]   ip_tos;
  logic [159:0] ip_hdr;
  logic [223:0] l3l4_hdr;
  logic [HB-1:0] hdr;

  assign ip_total_len  = payload_length_fifo_tdata + 16'd28;
  assign udp_len       = payload_length_fifo_tdata + 16'd8;
  assign ip_tos        = {IP_UDP_DSCP, IP_UDP_ECN};
  assign ip_flags_frag = {IP_UDP_FLAGS, 13'd0};
  assign ip_hdr = {IP_VERSION_IPV4, IP_IHL_WORDS, ip_tos, ip_total_len, ip_id_q, ip_flags_frag,
                   IP_UDP_TTL, IPPROTO_UDP, 16'h0000, my_config_ipAddr, dst_ip};

  ip_hdr_checksum u_csum (
    .hdr_i  (ip_hdr),
    .csum_o (ip_csum)
  );

  // Fields listed last-on-wire first so byte 0 lands in the LSBs.
  assign l3l4_hdr = {16'h0000, swap_bytes_2(udp_len), swap_bytes_2(dst_port),
                     swap_bytes_2(my_config_udpPort), swap_bytes_4(dst_ip),
                     swap_bytes_4(my_config_ipAddr), swap_bytes_2(ip_csum), IPPROTO_UDP,
                     IP_UDP_TTL, swap_bytes_2(ip_flags_frag), swap_bytes_2(ip_id_q),
                     swap_bytes_2(ip_total_len), ip_tos, IP_VERSION_IPV4, IP_IHL_WORDS};
`ifdef ZEUS_TX_VLAN_EN
  assign hdr = {l3l4_hdr, swap_bytes_2(ETHTYPE_IP), swap_bytes_2(my_config_vlanTci),
                swap_bytes_2(ETHTYPE_VLAN), swap_bytes_6(my_config_macAddr), swap_bytes_6(dst_mac)};
`else
  assign hdr = {l3l4_hdr, swap_bytes_2(ETHTYPE_IP), swap_bytes_6(my_config_macAddr),
                swap_bytes_6(dst_mac)};
`endif

  logic adv, all_valid, meta_pop, pkt_fire, emit_beat, beat_fits;
  logic [HB-1:0] beat_lo;

  assign adv       = !tvalid_q || m_axis_tready;
  assign all_valid = packet_fifo_tvalid && connection_fifo_tvalid && payload_length_fifo_tvalid;
  // Misses are swallowed without waiting on the output side.
  assign meta_pop  = !tx_axis_areset && (state_q == HEAD) && all_valid && (adv || !conn_hit);
  assign connection_fifo_tready     = meta_pop;
  assign payload_length_fifo_tready = meta_pop;
  assign packet_fifo_tready = meta_pop ||
                              (!tx_axis_areset && (((state_q == BODY) && adv) || (state_q == DROP)));
  assign pkt_fire  = packet_fifo_tvalid && packet_fifo_tready;
  assign emit_beat = pkt_fire && ((state_q == BODY) || ((state_q == HEAD) && conn_hit));
  // tkeep is contiguous, so "N <= PB" is simply "byte PB not kept".
  assign beat_fits = packet_fifo_tlast && !packet_fifo_tkeep[PB];
  assign beat_lo   = (state_q == HEAD) ? hdr : carry_q;

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    carry_d     = carry_q;
    tail_keep_d = tail_keep_q;
    ip_id_d     = ip_id_q;
    drop_cnt_d  = drop_cnt_q;
    after_beat  = beat_fits ? HEAD : (packet_fifo_tlast ? TAIL : BODY);
    if (adv) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    case (state_q)
      HEAD: begin
        if (meta_pop && conn_hit) begin
          ip_id_d = ip_id_q + 16'd1;
          state_d = after_beat;
        end else if (meta_pop) begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
          state_d = packet_fifo_tlast ? HEAD : DROP;
        end
      end
      BODY: if (pkt_fire) state_d = after_beat;
      TAIL: begin
        if (adv) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tdata_d  = {{(DATA_WIDTH-HB){1'b0}}, carry_q};
          tkeep_d  = {{PB{1'b0}}, tail_keep_q};
          state_d  = HEAD;
        end
      end
      DROP: if (pkt_fire && packet_fifo_tlast) state_d = HEAD;
      default: state_d = HEAD;
    endcase
    if (emit_beat) begin
      tvalid_d    = 1'b1;
      tlast_d     = beat_fits;
      tdata_d     = {packet_fifo_tdata[DATA_WIDTH-HB-1:0], beat_lo};
      tkeep_d     = beat_fits ? {packet_fifo_tkeep[PB-1:0], {H{1'b1}}} : '1;
      carry_d     = packet_fifo_tdata[DATA_WIDTH-1 -: HB];
      tail_keep_d = packet_fifo_tkeep[BYTES-1 -: H];
    end
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      state_q     <= HEAD;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      carry_q     <= '0;
      tail_keep_q <= '0;
      ip_id_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      carry_q     <= carry_d;
      tail_keep_q <= tail_keep_d;
      ip_id_q     <= ip_id_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tkeep    = tkeep_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tvalid   = tvalid_q;
  assign stat_drop_count = drop_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_tx_udp_encap.sv
// Bench for tx_udp_encap: frame-level byte model, beat scoreboard, directed and random packets.
module tb_tx_udp_encap;
  import zeus_rpc_pkg::*;

  localparam int W = 512;
  localparam int NB = W / 8;
  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'hC0A8_0001;
  localparam logic [15:0] MY_PORT = 16'd4791;
  localparam logic [15:0] TCI     = 16'h0005;

  logic clk, rst;
  logic [W-1:0] packet_fifo_tdata;
  logic [NB-1:0] packet_fifo_tkeep;
  logic packet_fifo_tlast, packet_fifo_tvalid, packet_fifo_tready;
  logic [96:0] connection_fifo_tdata;
  logic connection_fifo_tvalid, connection_fifo_tready;
  logic [15:0] payload_length_fifo_tdata;
  logic payload_length_fifo_tvalid, payload_length_fifo_tready;
  logic [W-1:0] m_axis_tdata;
  logic [NB-1:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [31:0] stat_drop_count;
  logic [1:0] dbg_state;

  tx_udp_encap #(.DATA_WIDTH(W)) dut (
    .tx_axis_aclk(clk), .tx_axis_areset(rst),
    .my_config_ipAddr(MY_IP), .my_config_macAddr(MY_MAC), .my_config_udpPort(MY_PORT),
`ifdef ZEUS_TX_VLAN_EN
    .my_config_vlanTci(TCI),
`endif
    .packet_fifo_tdata(packet_fifo_tdata), .packet_fifo_tkeep(packet_fifo_tkeep),
    .packet_fifo_tlast(packet_fifo_tlast), .packet_fifo_tvalid(packet_fifo_tvalid),
    .packet_fifo_tready(packet_fifo_tready),
    .connection_fifo_tdata(connection_fifo_tdata), .connection_fifo_tvalid(connection_fifo_tvalid),
    .connection_fifo_tready(connection_fifo_tready),
    .payload_length_fifo_tdata(payload_length_fifo_tdata),
    .payload_length_fifo_tvalid(payload_length_fifo_tvalid),
    .payload_length_fifo_tready(payload_length_fifo_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .stat_drop_count(stat_drop_count), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_err = 0;
  int id_model = 0, drops_model = 0;
  int frames_seen = 0, beat_in_frame = 0, last_frame_beats = 0, last_frame_keepcnt = 0;
  bit rand_ready = 1'b0;
  logic [W-1:0] first_beat_d;
  logic [W-1:0] exp_q[$];
  logic [NB-1:0] exp_keep_q[$];
  logic exp_last_q[$];

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole frame as bytes, then cut into NB-byte beats.
  task automatic model_push(input logic [47:0] dmac, input logic [15:0] dport,
                            input logic [31:0] dip, input logic [15:0] len,
                            input logic [15:0] id, input logic [7:0] pay[$]);
    logic [7:0] f[$];
    logic [31:0] s;
    logic [15:0] tl, ul;
    logic [W-1:0] d;
    logic [NB-1:0] k;
    int ip_off;
    tl = len + 16'd28;
    ul = len + 16'd8;
    for (int i = 5; i >= 0; i--) f.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(MY_MAC[8*i +: 8]);
`ifdef ZEUS_TX_VLAN_EN
    f.push_back(8'h81); f.push_back(8'h00); f.push_back(TCI[15:8]); f.push_back(TCI[7:0]);
`endif
    f.push_back(8'h08); f.push_back(8'h00);
    ip_off = f.size();
    f.push_back(8'h45); f.push_back(8'h00); f.push_back(tl[15:8]); f.push_back(tl[7:0]);
    f.push_back(id[15:8]); f.push_back(id[7:0]); f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'd64); f.push_back(8'd17); f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 3; i >= 0; i--) f.push_back(MY_IP[8*i +: 8]);
    for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
    s = 0;
    for (int i = 0; i < 20; i += 2) s = s + {16'h0, f[ip_off+i], f[ip_off+i+1]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    f[ip_off+10] = ~s[15:8];
    f[ip_off+11] = ~s[7:0];
    f.push_back(MY_PORT[15:8]); f.push_back(MY_PORT[7:0]);
    f.push_back(dport[15:8]); f.push_back(dport[7:0]);
    f.push_back(ul[15:8]); f.push_back(ul[7:0]); f.push_back(8'h00); f.push_back(8'h00);
    foreach (pay[i]) f.push_back(pay[i]);
    for (int b = 0; b < f.size(); b += NB) begin
      d = '0;
      k = '0;
      for (int j = 0; j < NB; j++) begin
        if (b + j < f.size()) begin
          d[8*j +: 8] = f[b+j];
          k[j] = 1'b1;
        end
      end
      exp_q.push_back(d);
      exp_keep_q.push_back(k);
      exp_last_q.push_back(b + NB >= f.size());
    end
  endtask

  // Driver tasks. Invariant: called and returning at posedge + #1.
  task automatic wait_fire(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (packet_fifo_tready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("fire_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_pkt(input bit hit, input int len, input int max_beats, input bit gaps);
    logic [47:0] dmac;
    logic [15:0] dport;
    logic [31:0] dip;
    logic [7:0] pay[$];
    logic [W-1:0] d;
    logic [NB-1:0] k;
    int beats;
    bit ok;
    dmac  = {16'($urandom), 32'($urandom)};
    dport = 16'($urandom);
    dip   = 32'($urandom);
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    if (hit) begin
      model_push(dmac, dport, dip, 16'(len), 16'(id_model), pay);
      id_model++;
    end else begin
      drops_model++;
    end
    beats = (len == 0) ? 1 : (len + NB - 1) / NB;
    if (max_beats > 0 && max_beats < beats) beats = max_beats;
    connection_fifo_tdata = {hit, dmac, dport, dip};
    payload_length_fifo_tdata = 16'(len);
    connection_fifo_tvalid = 1'b1;
    payload_length_fifo_tvalid = 1'b1;
    for (int b = 0; b < beats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        packet_fifo_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      d = '0;
      k = '0;
      for (int j = 0; j < NB; j++) begin
        if (b * NB + j < len) begin
          d[8*j +: 8] = pay[b*NB+j];
          k[j] = 1'b1;
        end
      end
      packet_fifo_tdata = d;
      packet_fifo_tkeep = k;
      packet_fifo_tlast = ((b + 1) * NB >= len);
      packet_fifo_tvalid = 1'b1;
      wait_fire(ok);
      if (ok && b == 0)
        check("meta_pop", {connection_fifo_tready, payload_length_fifo_tready}, 2'b11);
      @(posedge clk); #1;
      connection_fifo_tvalid = 1'b0;
      payload_length_fifo_tvalid = 1'b0;
      if (!ok) break;
    end
    packet_fifo_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_seen < n && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (frames_seen < n) check("frame_timeout", 32'(frames_seen), 32'(n));
  endtask

  // Output readiness: random 50% when enabled, otherwise always ready.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    logic [W-1:0] ed, mask, hold_d;
    logic [NB-1:0] ek, hold_k;
    logic el, hold_l;
    bit hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        beat_in_frame = 0;
        continue;
      end
      if (hold) check("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                      {1'b1, hold_l, hold_k, hold_d});
      hold = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_k = m_axis_tkeep;
      hold_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          ed = exp_q.pop_front();
          ek = exp_keep_q.pop_front();
          el = exp_last_q.pop_front();
          for (int j = 0; j < NB; j++) mask[8*j +: 8] = {8{ek[j]}};
          check("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata & mask}, {el, ek, ed});
          if (beat_in_frame == 0) first_beat_d = m_axis_tdata;
          beat_in_frame++;
          if (m_axis_tlast) begin
            last_frame_beats = beat_in_frame;
            last_frame_keepcnt = $countones(m_axis_tkeep);
            frames_seen++;
            beat_in_frame = 0;
          end
        end
      end
    end
  end

  typedef struct {
    int len;
    int exp_beats;
    int exp_last_bytes;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int t;
    vecs[0] = '{0, 1, 42};   vecs[1] = '{1, 1, 43};   vecs[2] = '{18, 1, 60};
    vecs[3] = '{22, 1, 64};  vecs[4] = '{23, 2, 1};   vecs[5] = '{64, 2, 42};
    vecs[6] = '{86, 2, 64};  vecs[7] = '{87, 3, 1};   vecs[8] = '{128, 3, 42};

    // Reset with upstream valids raised: no tready may leak out.
    rst = 1'b1;
    packet_fifo_tdata = '0; packet_fifo_tkeep = '0; packet_fifo_tlast = 1'b1;
    connection_fifo_tdata = {1'b1, 96'h0}; payload_length_fifo_tdata = 16'd0;
    packet_fifo_tvalid = 1'b1; connection_fifo_tvalid = 1'b1; payload_length_fifo_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
    check("rst_ready", {packet_fifo_tready, connection_fifo_tready, payload_length_fifo_tready}, 3'b000);
    check("rst_drop", stat_drop_count, 32'd0);
    check("rst_state", dbg_state, HEAD);
    packet_fifo_tvalid = 1'b0; connection_fifo_tvalid = 1'b0; payload_length_fifo_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Miss then hit: only the hit is emitted, carrying IP id 0.
    send_pkt(1'b0, 150, 0, 1'b0);
    send_pkt(1'b1, 40, 0, 1'b0);
    wait_frames(1);
    check("drop_cnt_1", stat_drop_count, 32'd1);
    check("ip_id_0", first_beat_d[18*8 +: 16], 16'h0000);

`ifdef ZEUS_TX_VLAN_EN
    send_pkt(1'b1, 22, 0, 1'b0);
    wait_frames(2);
    check("vlan_tag", first_beat_d[12*8 +: 32], 32'h0500_0081);
    check("vlan_frame_bytes", 32'((last_frame_beats - 1) * NB + last_frame_keepcnt), 32'd68);
`else
    send_pkt(1'b1, 18, 0, 1'b0);
    wait_frames(2);
    check("len18_total_len", first_beat_d[16*8 +: 16], 16'h2E00);
    foreach (vecs[i]) begin
      t = frames_seen;
      send_pkt(1'b1, vecs[i].len, 0, 1'b0);
      wait_frames(t + 1);
      check($sformatf("vec%0d_beats", i), 32'(last_frame_beats), 32'(vecs[i].exp_beats));
      check($sformatf("vec%0d_lastkeep", i), 32'(last_frame_keepcnt), 32'(vecs[i].exp_last_bytes));
    end
`endif

    // Reset while in BODY: output drops, state returns to HEAD, next packet is clean.
    send_pkt(1'b1, 150, 2, 1'b0);
    @(negedge clk);
    check("in_body", dbg_state, BODY);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_state", dbg_state, HEAD);
    exp_q.delete(); exp_keep_q.delete(); exp_last_q.delete();
    id_model = 0;
    drops_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    t = frames_seen;
    send_pkt(1'b1, 30, 0, 1'b0);
    wait_frames(t + 1);

    // Random traffic against a 50% ready output.
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++)
      send_pkt($urandom_range(0, 9) != 0, $urandom_range(1, 1500), 0, 1'b1);
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("drop_cnt_final", stat_drop_count, 32'(drops_model));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
